// File: rtl/command_frame_assembler.sv
// command_frame_assembler: builds 8-byte SPI command frames and serves back the core response byte-wise.
// Define FRAME_TIMEOUT_EN to discard partial frames after TIMEOUT_CYCLES idle cycles.
module command_frame_assembler #(
    parameter int RESP_DELAY     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    output logic [7:0]  tx_byte_o,
    output logic [7:0]  instruction_o,
    output logic [23:0] address_o,
    output logic [31:0] value_o,
    output logic        frame_valid_o,
    input  logic        frame_ready_i,
    input  logic [31:0] result_i,
    input  logic [31:0] stream_i,
    output logic        overflow_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} resp_state_t;

    resp_state_t state, state_next;
    logic [2:0]  idx, idx_next;
    logic [55:0] shadow;
    logic [31:0] resp;
    logic [7:0]  op_lat, tx_next;
    logic [3:0]  cnt;
    logic [63:0] tx_word;
    logic        complete, accept, pending, ovf_next, tmo_fire, tmo_next;

    if (RESP_DELAY < 1 || RESP_DELAY > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("command_frame_assembler: parameter out of range");
    end

    assign complete = rx_valid_i && idx == 3'd7;
    assign accept   = frame_valid_o && frame_ready_i;
    assign pending  = frame_valid_o && !frame_ready_i;
    assign ovf_next = overflow_o | (complete & pending);
    assign tmo_next = timeout_o | tmo_fire;
    assign idx_next = tmo_fire ? 3'd0 : rx_valid_i ? idx + 3'd1 : idx;

    // Status byte reflects flags as they will be after this cycle's event.
    assign tx_word = {ovf_next, tmo_next, 6'b0, resp, op_lat, 16'h0};
    assign tx_next = tx_word[{3'd7 - idx_next, 3'b0} +: 8];

`ifdef FRAME_TIMEOUT_EN
    logic [15:0] idle;

    assign tmo_fire = !rx_valid_i && idx != 3'd0 && idle == 16'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle      <= '0;
            timeout_o <= 1'b0;
        end else if (rx_valid_i || tmo_fire) begin
            idle      <= '0;
            timeout_o <= tmo_next;
        end else if (idx != 3'd0) begin
            idle      <= idle + 16'd1;
        end
    end
`else
    assign tmo_fire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx           <= '0;
            shadow        <= '0;
            tx_byte_o     <= '0;
            instruction_o <= '0;
            address_o     <= '0;
            value_o       <= '0;
            frame_valid_o <= 1'b0;
            overflow_o    <= 1'b0;
        end else begin
            idx        <= idx_next;
            overflow_o <= ovf_next;
            if (tmo_fire)
                shadow <= '0;
            else if (rx_valid_i)
                shadow <= {shadow[47:0], rx_byte_i};
            if (rx_valid_i || tmo_fire)
                tx_byte_o <= tx_next;
            if (complete && !pending) begin
                {instruction_o, address_o, value_o} <= {shadow, rx_byte_i};
                frame_valid_o <= 1'b1;
            end else if (accept) begin
                frame_valid_o <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = IDLE;
        if (accept)
            state_next = (RESP_DELAY == 1) ? CAPTURE : WAIT;
        else if (state == WAIT)
            state_next = (cnt == 4'(RESP_DELAY - 1)) ? CAPTURE : WAIT;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            op_lat <= '0;
            resp   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_lat <= instruction_o;
                cnt    <= 4'd1;
            end else if (state == WAIT) begin
                cnt    <= cnt + 4'd1;
            end
            if (state == CAPTURE)
                resp <= op_lat == 8'h02 ? result_i : op_lat == 8'h03 ? stream_i : resp;
        end
    end
endmodule
